// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo delay-line effect blocks.
package echo_pkg;

    typedef enum logic [2:0] {CLEAR, IDLE, RD, MIX, WR, OUT} state_e;

    localparam int VOL_MIN = 1;
    localparam int VOL_MAX = 6;
    localparam int DLY_MIN = 1;

    // Signed add of two sign-extended operands, saturated to a w-bit signed range (w <= 31).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned        w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return s[31:0];
    endfunction

endpackage

// File: rtl/echo_mix.sv
// Combinational echo mix: attenuate the delayed sample by an arithmetic shift,
// add it to the dry sample with saturation, or pass the dry sample when bypassed.
module echo_mix
    import echo_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] dly_i,
    input  logic [2:0]        vol_i,
    input  logic              dis_i,
    output logic [DATA_W-1:0] mix_o
);

    logic signed [DATA_W-1:0] echo;
    logic signed [31:0]       sum;

    always_comb begin
        echo  = $signed(dly_i) >>> vol_i;
        sum   = sat_add($signed({{(32-DATA_W){echo[DATA_W-1]}}, echo}),
                        $signed({{(32-DATA_W){sample_i[DATA_W-1]}}, sample_i}),
                        DATA_W);
        mix_o = dis_i ? sample_i : sum[DATA_W-1:0];
    end

endmodule

// File: rtl/echo_delay_scheduler.sv
// Per-sample sequencer for one channel's echo delay line: clear the buffer once,
// then read the delayed sample, mix, write back the mix and present it.
module echo_delay_scheduler
    import echo_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [31:0]       delay_time,
    input  logic [31:0]       delay_volume,
    input  logic              disabled,
    output logic              ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic              overrun,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [31:0] DMAX = (32'd1 << ADDR_W) - 32'd1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                clr_go_q;
    logic [DATA_W-1:0]   smp_q, dly_q, m_q, sout_q;
    logic                dis_q;
    logic [ADDR_W-1:0]   d_q, d_clamp;
    logic [2:0]          v_q, v_clamp;
    logic [DATA_W-1:0]   mix;

    echo_mix #(.DATA_W(DATA_W)) u_mix (
        .sample_i (smp_q),
        .dly_i    (dly_q),
        .vol_i    (v_q),
        .dis_i    (dis_q),
        .mix_o    (mix)
    );

    always_comb begin
        d_clamp = delay_time[ADDR_W-1:0];
        if (delay_time < 32'(DLY_MIN))
            d_clamp = ADDR_W'(DLY_MIN);
        else if (delay_time > DMAX)
            d_clamp = DMAX[ADDR_W-1:0];
        v_clamp = delay_volume[2:0];
        if (delay_volume < 32'(VOL_MIN))
            v_clamp = 3'(VOL_MIN);
        else if (delay_volume > 32'(VOL_MAX))
            v_clamp = 3'(VOL_MAX);
    end

    // clr_go_q holds off the first clear request until the cycle after reset
    // release, so an ack left over from before reset cannot complete it.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        ready     = 1'b0;
        out_valid = 1'b0;
        overrun   = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            CLEAR: begin
                mem_req  = clr_go_q;
                mem_wr   = clr_go_q;
                mem_addr = clr_cnt_q;
                if (clr_go_q && mem_ack) begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1)
                        state_d = IDLE;
                end
            end
            IDLE: begin
                ready = 1'b1;
                if (sample_valid)
                    state_d = RD;
            end
            RD: begin
                overrun  = sample_valid;
                mem_req  = 1'b1;
                mem_addr = wr_ptr_q - d_q;
                if (mem_ack)
                    state_d = MIX;
            end
            MIX: begin
                overrun = sample_valid;
                state_d = WR;
            end
            WR: begin
                overrun   = sample_valid;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = m_q;
                if (mem_ack)
                    state_d = OUT;
            end
            OUT: begin
                overrun   = sample_valid;
                out_valid = 1'b1;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign sample_out = sout_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= CLEAR;
            clr_go_q  <= 1'b0;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            smp_q     <= '0;
            dis_q     <= 1'b0;
            d_q       <= '0;
            v_q       <= '0;
            dly_q     <= '0;
            m_q       <= '0;
            sout_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_go_q  <= 1'b1;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            if (state_q == IDLE && sample_valid) begin
                smp_q <= sample_in;
                dis_q <= disabled;
                d_q   <= d_clamp;
                v_q   <= v_clamp;
            end
            if (state_q == RD && mem_ack)
                dly_q <= mem_rdata;
            if (state_q == MIX)
                m_q <= mix;
            // Loaded on the write ack so the new value appears with out_valid.
            if (state_q == WR && mem_ack)
                sout_q <= m_q;
        end
    end

endmodule
